// File: rtl/tt_sel_seq.sv
// Design-select sequencer for a row/column mux tree.
// Resets the mux selection counter, walks it forward with inc pulses up to the
// requested {Y,X} code, then enables the chosen design and holds it in reset
// for a fixed time before declaring it active.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no design enabled, waiting for a select request
// SEL_RST | selection counter held in reset (ctrl_sel_rst_n low)
// INC_HI  | inc pulse high phase; cur_sel advanced on entry
// INC_LO  | inc pulse low phase; decides whether target is reached
// UM_RST  | design enabled, user reset asserted
// RUN     | design enabled and out of reset; reselect allowed
module tt_sel_seq #(
   parameter int unsigned G_X         = 16,
   parameter int unsigned G_Y         = 24,
   parameter int unsigned PULSE_LEN   = 1,
   parameter int unsigned SEL_RST_LEN = 2,
   parameter int unsigned UM_RST_LEN  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic [9:0] req_addr,
   output logic       req_ready,
   output logic       req_err,
   output logic       ctrl_sel_rst_n,
   output logic       ctrl_sel_inc,
   output logic       ctrl_ena,
   output logic       um_rst_n,
   output logic       busy,
   output logic       active,
   output logic [9:0] cur_sel
);

   typedef enum logic [2:0] {
      IDLE,
      SEL_RST,
      INC_HI,
      INC_LO,
      UM_RST,
      RUN
   } state_t;

   // one shared down-counter serves every timed state, so size it for the longest
   localparam int unsigned TMR_MAX_A = (PULSE_LEN > SEL_RST_LEN) ? PULSE_LEN : SEL_RST_LEN;
   localparam int unsigned TMR_MAX   = (TMR_MAX_A > UM_RST_LEN) ? TMR_MAX_A : UM_RST_LEN;
   localparam int unsigned TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   localparam logic [TMR_W-1:0] PULSE_LD   = TMR_W'(PULSE_LEN - 1);
   localparam logic [TMR_W-1:0] SEL_RST_LD = TMR_W'(SEL_RST_LEN - 1);
   localparam logic [TMR_W-1:0] UM_RST_LD  = TMR_W'(UM_RST_LEN - 1);

   state_t           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [9:0]       tgt_q, tgt_d;
   logic [9:0]       cur_sel_q, cur_sel_d;
   logic             req_err_q, req_err_d;
   logic             sel_rst_n_q, sel_rst_n_d;
   logic             sel_inc_q, sel_inc_d;
   logic             ena_q, ena_d;
   logic             um_rst_n_q, um_rst_n_d;
   logic             busy_q, busy_d;
   logic             active_q, active_d;
   logic             req_legal;
   logic             tmr_done;
   logic             at_target;

   assign req_legal = (32'(req_addr[9:5]) < G_Y) && (32'(req_addr[4:0]) < G_X);
   assign tmr_done  = (tmr_q == '0);
   assign at_target = (cur_sel_q == tgt_q);
   assign req_ready = (state_q == IDLE) || (state_q == RUN);

   // next-state, timer reloads and selection bookkeeping
   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      tgt_d     = tgt_q;
      cur_sel_d = cur_sel_q;
      req_err_d = 1'b0;
      case (state_q)
         IDLE, RUN: begin
            if (req_valid) begin
               if (req_legal) begin
                  state_d   = SEL_RST;
                  tmr_d     = SEL_RST_LD;
                  tgt_d     = req_addr;
                  cur_sel_d = '0;
               end else begin
                  req_err_d = 1'b1;
               end
            end
         end
         SEL_RST, INC_LO: begin
            if (tmr_done) begin
               if (at_target) begin
                  state_d = UM_RST;
                  tmr_d   = UM_RST_LD;
               end else begin
                  state_d   = INC_HI;
                  tmr_d     = PULSE_LD;
                  cur_sel_d = cur_sel_q + 10'd1;
               end
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         INC_HI: begin
            if (tmr_done) begin
               state_d = INC_LO;
               tmr_d   = PULSE_LD;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         UM_RST: begin
            if (tmr_done) begin
               state_d = RUN;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // outputs decoded from the next state so they change on the same edge as the state
   always_comb begin
      sel_rst_n_d = (state_d != SEL_RST);
      sel_inc_d   = (state_d == INC_HI);
      ena_d       = (state_d == UM_RST) || (state_d == RUN);
      um_rst_n_d  = (state_d != UM_RST);
      busy_d      = (state_d == SEL_RST) || (state_d == INC_HI) ||
                    (state_d == INC_LO)  || (state_d == UM_RST);
      active_d    = (state_d == RUN);
   end

   // state and output registers; reset holds both the mux and the user design in reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         tmr_q       <= '0;
         tgt_q       <= '0;
         cur_sel_q   <= '0;
         req_err_q   <= 1'b0;
         sel_rst_n_q <= 1'b0;
         sel_inc_q   <= 1'b0;
         ena_q       <= 1'b0;
         um_rst_n_q  <= 1'b0;
         busy_q      <= 1'b0;
         active_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         tgt_q       <= tgt_d;
         cur_sel_q   <= cur_sel_d;
         req_err_q   <= req_err_d;
         sel_rst_n_q <= sel_rst_n_d;
         sel_inc_q   <= sel_inc_d;
         ena_q       <= ena_d;
         um_rst_n_q  <= um_rst_n_d;
         busy_q      <= busy_d;
         active_q    <= active_d;
      end
   end

   assign req_err        = req_err_q;
   assign ctrl_sel_rst_n = sel_rst_n_q;
   assign ctrl_sel_inc   = sel_inc_q;
   assign ctrl_ena       = ena_q;
   assign um_rst_n       = um_rst_n_q;
   assign busy           = busy_q;
   assign active         = active_q;
   assign cur_sel        = cur_sel_q;

endmodule

// File: tb/tb_tt_sel_seq.sv
// Directed bench for tt_sel_seq with default parameters.
module tb_tt_sel_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic [9:0] req_addr;
   logic       req_ready;
   logic       req_err;
   logic       ctrl_sel_rst_n;
   logic       ctrl_sel_inc;
   logic       ctrl_ena;
   logic       um_rst_n;
   logic       busy;
   logic       active;
   logic [9:0] cur_sel;

   int n_chk  = 0;
   int n_fail = 0;

   int   r50_rise;
   logic r50_prev;
   bit   r50_hit;

   // vector order: {sel_rst_n, sel_inc, ena, um_rst_n, busy, active}
   localparam logic [5:0] V_RESET = 6'b000000;
   localparam logic [5:0] V_IDLE  = 6'b100100;
   localparam logic [5:0] V_RUN   = 6'b101101;

   always #5 clk = ~clk;

   tt_sel_seq dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_addr       (req_addr),
      .req_ready      (req_ready),
      .req_err        (req_err),
      .ctrl_sel_rst_n (ctrl_sel_rst_n),
      .ctrl_sel_inc   (ctrl_sel_inc),
      .ctrl_ena       (ctrl_ena),
      .um_rst_n       (um_rst_n),
      .busy           (busy),
      .active         (active),
      .cur_sel        (cur_sel)
   );

   function automatic logic [5:0] out_vec();
      return {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, um_rst_n, busy, active};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // offer an illegal address for one cycle; expect a single err pulse and frozen outputs
   task automatic illegal(input logic [9:0] addr, input logic [5:0] exp_vec, input string tag);
      req_addr  = addr;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      check({tag, "_err_hi"}, 32'(req_err), 32'd1);
      check({tag, "_vec1"}, 32'(out_vec()), 32'(exp_vec));
      @(negedge clk);
      check({tag, "_err_lo"}, 32'(req_err), 32'd0);
      check({tag, "_vec2"}, 32'(out_vec()), 32'(exp_vec));
   endtask

   // full select sequence; exp_n is the hand-computed inc pulse count for addr
   task automatic run_seq(input logic [9:0] addr, input bit hold, input int exp_n, input string tag);
      int   srst = 0, rise = 0, inc_hi = 0, umrst = 0, bsy = 0;
      int   rdy_bsy = 0, ena_srst = 0, errs = 0;
      logic prev = 1'b0;
      bit   done = 1'b0;
      req_addr  = addr;
      req_valid = 1'b1;
      @(negedge clk);
      check({tag, "_first_ena"}, 32'(ctrl_ena), 32'd0);
      check({tag, "_first_act"}, 32'(active), 32'd0);
      check({tag, "_first_srst"}, 32'(ctrl_sel_rst_n), 32'd0);
      for (int i = 0; i < 3000 && !done; i++) begin
         if (i > 0) @(negedge clk);
         if (!hold) req_valid = 1'b0;
         if (!ctrl_sel_rst_n) srst++;
         if (ctrl_sel_inc && !prev) rise++;
         if (ctrl_sel_inc) inc_hi++;
         if (ctrl_ena && !um_rst_n) umrst++;
         if (busy) bsy++;
         if (busy && req_ready) rdy_bsy++;
         if (!ctrl_sel_rst_n && ctrl_ena) ena_srst++;
         if (req_err) errs++;
         prev = ctrl_sel_inc;
         if (active) done = 1'b1;
      end
      req_valid = 1'b0;
      check({tag, "_reached_run"}, 32'(done), 32'd1);
      check({tag, "_srst_cycles"}, 32'(srst), 32'd2);
      check({tag, "_inc_pulses"}, 32'(rise), 32'(exp_n));
      check({tag, "_inc_hi_cycles"}, 32'(inc_hi), 32'(exp_n));
      check({tag, "_umrst_cycles"}, 32'(umrst), 32'd8);
      check({tag, "_busy_cycles"}, 32'(bsy), 32'(2 + 2 * exp_n + 8));
      check({tag, "_ready_in_busy"}, 32'(rdy_bsy), 32'd0);
      check({tag, "_ena_in_srst"}, 32'(ena_srst), 32'd0);
      check({tag, "_err_pulses"}, 32'(errs), 32'd0);
      check({tag, "_cur_sel"}, 32'(cur_sel), 32'(exp_n));
      check({tag, "_run_vec"}, 32'(out_vec()), 32'(V_RUN));
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_addr  = '0;
      repeat (3) @(negedge clk);
      check("rst_vec", 32'(out_vec()), 32'(V_RESET));
      check("rst_err", 32'(req_err), 32'd0);
      check("rst_cur_sel", 32'(cur_sel), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_vec", 32'(out_vec()), 32'(V_IDLE));
      check("idle_ready", 32'(req_ready), 32'd1);

      illegal(10'h300, V_IDLE, "idle_bad_y");
      illegal(10'h010, V_IDLE, "idle_bad_x");

      run_seq(10'h0A7, 1'b0, 167, "sel_5_7");

      illegal(10'h300, V_RUN, "run_bad_y");
      illegal(10'h010, V_RUN, "run_bad_x");
      check("run_still_active", 32'(active), 32'd1);

      run_seq(10'h022, 1'b0, 34, "resel_1_2");
      run_seq(10'h000, 1'b0, 0, "sel_0_0");

      // abort while the 50th inc pulse is high
      req_addr  = 10'h0A7;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      r50_rise  = 0;
      r50_prev  = 1'b0;
      r50_hit   = 1'b0;
      for (int i = 0; i < 1000 && !r50_hit; i++) begin
         @(negedge clk);
         if (ctrl_sel_inc && !r50_prev) r50_rise++;
         r50_prev = ctrl_sel_inc;
         if (r50_rise == 50 && ctrl_sel_inc) r50_hit = 1'b1;
      end
      check("r50_reached", 32'(r50_hit), 32'd1);
      check("r50_cur_sel", 32'(cur_sel), 32'd50);
      rst = 1'b1;
      @(negedge clk);
      check("r50_rst_vec", 32'(out_vec()), 32'(V_RESET));
      check("r50_rst_cur_sel", 32'(cur_sel), 32'd0);
      check("r50_rst_err", 32'(req_err), 32'd0);
      check("r50_rst_ready", 32'(req_ready), 32'd1);
      rst = 1'b0;
      @(negedge clk);
      check("r50_idle_vec", 32'(out_vec()), 32'(V_IDLE));
      run_seq(10'h022, 1'b0, 34, "after_rst");

      run_seq(10'h003, 1'b1, 3, "hold_valid");
      @(negedge clk);
      check("hold_stays_run", 32'(out_vec()), 32'(V_RUN));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/tt_sel_seq.md
TT_SEL_SEQ -- requirements
Module: tt_sel_seq

Interface
REQ-001 SHALL have parameter G_X, default 16, meaning the number of mux columns; X addresses 0..G_X-1 are legal.
REQ-002 SHALL have parameter G_Y, default 24, meaning the number of mux rows; Y addresses 0..G_Y-1 are legal.
REQ-003 SHALL have parameter PULSE_LEN, default 1, meaning ctrl_sel_inc high time and low time, in clk cycles (>=1).
REQ-004 SHALL have parameter SEL_RST_LEN, default 2, meaning ctrl_sel_rst_n low time in clk cycles (>=1).
REQ-005 SHALL have parameter UM_RST_LEN, default 8, meaning user-design reset (um_rst_n low) time in clk cycles after enable (>=1).
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port req_valid, input, 1 bit: a design-select request is present.
REQ-009 SHALL have port req_addr, input, 10 bits: {Y[4:0], X[4:0]} of the requested design.
REQ-010 SHALL have port req_ready, output, 1 bit: a request is accepted this cycle if req_valid is also high.
REQ-011 SHALL have port req_err, output, 1 bit: one-cycle pulse when an illegal address is offered.
REQ-012 SHALL have port ctrl_sel_rst_n, output, 1 bit: mux selection-counter reset, active low.
REQ-013 SHALL have port ctrl_sel_inc, output, 1 bit: mux selection-counter increment; each rising edge advances the selection by 1.
REQ-014 SHALL have port ctrl_ena, output, 1 bit: enable for the selected design.
REQ-015 SHALL have port um_rst_n, output, 1 bit: reset line to the user design, active low.
REQ-016 SHALL have port busy, output, 1 bit: a sequence is in progress.
REQ-017 SHALL have port active, output, 1 bit: the selected design is enabled and out of reset.
REQ-018 SHALL have port cur_sel, output, 10 bits: the number of inc pulses issued since the last selection reset.

Function
REQ-019 SHALL implement the states IDLE, SEL_RST, INC_HI, INC_LO, UM_RST and RUN.
REQ-020 req_ready SHALL be 1 only in IDLE or RUN; req_valid in any other state SHALL be ignored without any pulse.
REQ-021 An accepted request SHALL be checked for legality: Y<G_Y and X<G_X. An illegal request SHALL produce req_err=1 in the next cycle, leave the state and all outputs unchanged, and leave a RUN session running.
REQ-022 A legal accept at edge k SHALL latch the target {Y,X} and clear cur_sel. From edge k onward it SHALL drive ctrl_ena=0, um_rst_n=1 and ctrl_sel_rst_n=0 for exactly SEL_RST_LEN cycles, in state SEL_RST.
REQ-023 After SEL_RST, the block SHALL go to UM_RST if cur_sel equals the target, otherwise to INC_HI.
REQ-024 INC_HI SHALL drive ctrl_sel_inc=1 for PULSE_LEN cycles, and SHALL increment cur_sel on entry.
REQ-025 INC_LO SHALL drive ctrl_sel_inc=0 for PULSE_LEN cycles.
REQ-026 At the end of INC_LO, the block SHALL go to UM_RST if cur_sel equals the target, otherwise back to INC_HI.
REQ-027 The inc pulse count SHALL equal the target value interpreted as a 10-bit unsigned integer ({Y,X}), not Y*G_X+X.
REQ-028 UM_RST SHALL drive ctrl_ena=1 and um_rst_n=0 for UM_RST_LEN cycles, then enter RUN.
REQ-029 RUN SHALL hold ctrl_ena=1, um_rst_n=1 and active=1.
REQ-030 busy SHALL be 1 in SEL_RST, INC_HI, INC_LO and UM_RST, and 0 otherwise.
REQ-031 Outside SEL_RST, ctrl_sel_rst_n SHALL be 1; outside INC_HI, ctrl_sel_inc SHALL be 0.
REQ-032 A legal request accepted in RUN SHALL drop ctrl_ena and active from the accept edge and restart at SEL_RST (reselect).
REQ-033 All outputs SHALL be registered, with no combinational path from req_* to ctrl_*; req_ready SHALL be a decode of the state only.
REQ-034 Timer widths SHALL be sized from the parameters, so that no timer wraps before reaching its terminal count.

Reset
REQ-035 While rst=1 at a clock edge, the block SHALL go to IDLE with ctrl_sel_rst_n=0, ctrl_sel_inc=0, ctrl_ena=0, um_rst_n=0, req_err=0, busy=0, active=0 and cur_sel=0.
REQ-036 In IDLE after reset, the block SHALL drive ctrl_sel_rst_n=1 and um_rst_n=1, and SHALL NOT re-enable any design.
REQ-037 rst asserted mid-sequence, including during INC_HI, SHALL abort at the next edge with the REQ-035 values.

Verification
REQ-038 SHALL cover: request {5,7}=0x0A7 with default parameters -> sel_rst_n low 2 cycles, exactly 167 inc pulses (1 high, 1 low), ena high with um_rst_n low 8 cycles, then active=1; cur_sel=167.
REQ-039 SHALL cover: request {0,0} -> no inc pulses, UM_RST directly after SEL_RST, active after 2+8 cycles.
REQ-040 SHALL cover: request Y=24 and a separate request X=16 -> req_err pulse of 1 cycle each, no ctrl_* change; also repeat while in RUN -> session stays active.
REQ-041 SHALL cover: while in RUN on {5,7}, request {1,2} -> ena drops on the accept edge, selection reset, 34 pulses, re-enable.
REQ-042 SHALL cover: rst during the 50th inc pulse -> next edge shows all REQ-035 values; a subsequent request completes normally.
REQ-043 SHALL cover: req_valid held high during busy -> ignored, exactly one sequence, req_ready=0 throughout.
